det_seq: RTL
============

Name: det_seq

Overview:
- Sequential signed determinant engine for 2x2 and 3x3 matrices, selected at run time. Successor to the combinational 2x2 determinant unit.
- Uses one shared multiplier and a start/done handshake. Element width is parametrised.
- Full-precision result, saturated or wrapped result, and overflow flag are all available.
- Sits behind the coprocessor instruction decoder; operands come from the matrix register bank.

Parameters:
- DATA_W, 8: signed element width and width of the narrow det output.
- SAT, 1: 1 = det saturates to the DATA_W range; 0 = det is the low DATA_W bits of det_full.
- Derived, not overridable: ACC_W = 3*DATA_W+3.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only while busy=0.
- size  in  1  0 = 2x2 (uses elements (0,0),(0,1),(1,0),(1,1)); 1 = 3x3.
- mat  in  9*DATA_W  row-major signed elements; element (r,c) is at bits [(3r+c)*DATA_W +: DATA_W]; unused elements are ignored.
- busy  out  1  high from the accepting edge until done rises.
- done  out  1  one-cycle pulse; results are valid from this cycle onward.
- det  out  DATA_W  signed narrow result (saturated or wrapped per SAT).
- det_full  out  ACC_W  signed exact determinant.
- ovf  out  1  exact result is outside [-2^(DATA_W-1), 2^(DATA_W-1)-1]; independent of SAT.

Behaviour:
- Reset (rst=0, asynchronous):
  - FSM goes to IDLE.
  - busy, done, det, det_full, ovf and all internal registers are set to 0.
  - An operation in progress is abandoned and no done is produced.
- FSM states: IDLE, MINOR_A, MINOR_B, ACCUM, DONE_ST. A column index col counts 0..2.
- IDLE:
  - On an edge with start=1: latch mat and size, clear the accumulator, set col=0, busy=1, go to MINOR_A.
  - Inputs are ignored after latching.
- MINOR_A: multiplier computes the first product of the current 2x2 minor, held in a (2*DATA_W+1)-bit register. Go to MINOR_B.
- MINOR_B: subtract the second product to form the minor.
  - size=0: minor = a00*a11 - a01*a10; the result is the minor; go to DONE_ST.
  - size=1: minor for column col, using rows 1-2 and the two other columns in ascending order; go to ACCUM.
- ACCUM (3x3 only):
  - acc += s*a0,col*minor, with s=+1 for col 0 and 2, s=-1 for col 1.
  - If col=2, go to DONE_ST; otherwise col++ and go to MINOR_A.
- DONE_ST:
  - Register det_full, det and ovf; pulse done=1, set busy=0, go to IDLE. done is high in the following cycle only.
- Latency, from the edge sampling start to the edge raising done: 3 cycles for 2x2, 10 cycles for 3x3.
- Back-to-back: a start sampled in the cycle where done=1 is accepted at that edge.
- start while busy=1 is ignored: no queuing, no effect on the operation in progress.
- Arithmetic:
  - All products and sums are sign-extended to the widths above.
  - acc is ACC_W wide and never overflows internally.
- Output rules:
  - det saturates to 2^(DATA_W-1)-1 or -2^(DATA_W-1) when SAT=1 and ovf=1.
  - Outputs hold their values until the next done.
- Exactly one multiplier instance. No combinational path from inputs to outputs.

Test Plan (DATA_W=8, SAT=1 unless stated):
- size=0, mat rows [2,3],[4,2] -> done 3 cycles after start; det=8'hF8 (-8), det_full=-8, ovf=0.
- size=1, rows [1,2,3],[4,5,6],[7,8,10] -> done 10 cycles after start; det=-3, ovf=0. Repeat with the zero-diagonal rows [0,5],[3,0] at size=0 -> det=-15.
- Overflow, size=0, rows [127,-128],[127,127]:
  - SAT=1 -> det_full=32385, det=127, ovf=1.
  - Re-run with SAT=0 -> det=8'h81, ovf=1.
- Pulse start again 4 cycles into a 3x3 operation while also changing mat -> result unchanged, exactly one done pulse.
- Drive rst=0 mid 3x3 operation -> busy, done and det go to 0 immediately; no done after release. A new start then completes normally.
- Back-to-back: hold start=1 across the done cycle, alternating size=0 then size=1 -> both results correct, second done 10 cycles after the first.

Source files
------------

// File: rtl/det_seq.sv
// rtl/det_seq.sv - sequential signed 2x2/3x3 determinant engine with one shared multiplier
module det_seq #(
    parameter int DATA_W = 8,
    parameter int SAT    = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    size,
    input  logic [9*DATA_W-1:0]     mat,
    output logic                    busy,
    output logic                    done,
    output logic [DATA_W-1:0]       det,
    output logic [3*DATA_W+2:0]     det_full,
    output logic                    ovf
);

    localparam int ACC_W = 3*DATA_W + 3;
    localparam int MW    = 2*DATA_W + 1;   // minor / first-product width
    localparam int PW    = 3*DATA_W + 1;   // shared multiplier product width

    typedef enum logic [2:0] {IDLE, MINOR_A, MINOR_B, ACCUM, DONE_ST} state_t;

    state_t                     state;
    logic [1:0]                 col;
    logic                       size_q;
    logic [9*DATA_W-1:0]        mat_q;
    logic signed [MW-1:0]       p1;
    logic signed [MW-1:0]       minor;
    logic signed [ACC_W-1:0]    acc;

    logic signed [DATA_W-1:0]   ea;
    logic signed [DATA_W-1:0]   eb;
    logic signed [MW-1:0]       op_b;
    logic signed [PW-1:0]       mul_xa;
    logic signed [PW-1:0]       mul_xb;
    logic signed [PW-1:0]       mul_p;
    logic signed [MW-1:0]       minor_n;
    logic signed [ACC_W-1:0]    acc_term;
    logic [ACC_W-DATA_W:0]      top_bits;
    logic                       in_rng;
    logic [DATA_W-1:0]          det_sat;
    logic [DATA_W-1:0]          det_n;
    int                         row_b;
    int                         c_lo;
    int                         c_hi;

    function automatic logic signed [DATA_W-1:0] elem(input logic [9*DATA_W-1:0] m,
                                                      input int r, input int c);
        return m[(3*r+c)*DATA_W +: DATA_W];
    endfunction

    // Select multiplier operands: minor products in MINOR_A/B, cofactor weighting in ACCUM.
    // A 2x2 is treated as the minor on rows 0-1, columns 0-1.
    always_comb begin
        row_b = 0;
        c_lo  = 0;
        c_hi  = 1;
        if (size_q) begin
            row_b = 1;
            case (col)
                2'd0:    begin c_lo = 1; c_hi = 2; end
                2'd1:    begin c_lo = 0; c_hi = 2; end
                default: begin c_lo = 0; c_hi = 1; end
            endcase
        end
        ea   = '0;
        eb   = '0;
        op_b = '0;
        case (state)
            MINOR_A: begin
                ea   = elem(mat_q, row_b, c_lo);
                eb   = elem(mat_q, row_b + 1, c_hi);
                op_b = {{(MW-DATA_W){eb[DATA_W-1]}}, eb};
            end
            MINOR_B: begin
                ea   = elem(mat_q, row_b, c_hi);
                eb   = elem(mat_q, row_b + 1, c_lo);
                op_b = {{(MW-DATA_W){eb[DATA_W-1]}}, eb};
            end
            ACCUM: begin
                ea   = elem(mat_q, 0, int'(col));
                op_b = minor;
            end
            default: begin
                ea   = '0;
                op_b = '0;
            end
        endcase
        mul_xa = {{(PW-DATA_W){ea[DATA_W-1]}}, ea};
        mul_xb = {{(PW-MW){op_b[MW-1]}}, op_b};
    end

    // The single multiplier; operands are pre-extended so the low PW bits are exact.
    assign mul_p    = mul_xa * mul_xb;
    assign minor_n  = p1 - mul_p[MW-1:0];
    assign acc_term = {{(ACC_W-PW){mul_p[PW-1]}}, mul_p};

    // Range check and narrowing of the accumulated result.
    always_comb begin
        top_bits = acc[ACC_W-1:DATA_W-1];
        in_rng   = (&top_bits) | (~|top_bits);
        det_sat  = acc[ACC_W-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
        det_n    = ((SAT != 0) && !in_rng) ? det_sat : acc[DATA_W-1:0];
    end

    // Control FSM, datapath registers and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            col      <= '0;
            size_q   <= 1'b0;
            mat_q    <= '0;
            p1       <= '0;
            minor    <= '0;
            acc      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            det      <= '0;
            det_full <= '0;
            ovf      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        mat_q  <= mat;
                        size_q <= size;
                        acc    <= '0;
                        col    <= '0;
                        busy   <= 1'b1;
                        state  <= MINOR_A;
                    end
                end
                MINOR_A: begin
                    p1    <= mul_p[MW-1:0];
                    state <= MINOR_B;
                end
                MINOR_B: begin
                    if (!size_q) begin
                        acc   <= {{(ACC_W-MW){minor_n[MW-1]}}, minor_n};
                        state <= DONE_ST;
                    end else begin
                        minor <= minor_n;
                        state <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (col == 2'd1) begin
                        acc <= acc - acc_term;
                    end else begin
                        acc <= acc + acc_term;
                    end
                    if (col == 2'd2) begin
                        state <= DONE_ST;
                    end else begin
                        col   <= col + 2'd1;
                        state <= MINOR_A;
                    end
                end
                DONE_ST: begin
                    det_full <= acc;
                    det      <= det_n;
                    ovf      <= !in_rng;
                    done     <= 1'b1;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
